cpu5_wbck: RTL and testbench
============================

// Module: cpu5_wbck
// PURPOSE
//  Writeback stage directly upstream of the integer register file.
//  Arbitrates between two result producers, ALU (single-cycle) and LSU (load return),
//  and registers the winner into a single rf write (wen/idx/data) for the register file.
//  Loads have priority, and an anti-starvation counter guarantees the ALU progresses.
// PARAMETERS
//  XLEN        `CPU5_XLEN (32)        data width
//  RFIDX_W     `CPU5_RFIDX_WIDTH (5)  register index width
//  STARVE_MAX  4                      max consecutive ALU losses before forced ALU grant; legal range >=1
// PORTS
//  clk            in   1        clock; all state on rising edge
//  rst            in   1        reset, synchronous, active-low (0 = reset)
//  alu_wbck_valid in   1        ALU result valid
//  alu_wbck_ready out  1        ALU result accepted this cycle
//  alu_wbck_idx   in   RFIDX_W  ALU destination register
//  alu_wbck_data  in   XLEN     ALU result
//  lsu_wbck_valid in   1        load result valid
//  lsu_wbck_ready out  1        load result accepted this cycle
//  lsu_wbck_idx   in   RFIDX_W  load destination register
//  lsu_wbck_data  in   XLEN     load data
//  lsu_wbck_err   in   1        load faulted; no register write
//  rf_wen         out  1        regfile write enable (registered)
//  rf_idx         out  RFIDX_W  regfile write index (registered)
//  rf_data        out  XLEN     regfile write data (registered)
//  wbck_lsu_err   out  1        one-cycle pulse: faulted load retired
// BEHAVIOUR
//  - Reset: rf_wen=0, rf_idx=0, rf_data=0, wbck_lsu_err=0, starve_cnt=0. Reset overrides any transfer in flight. Producers must hold valid.
//  - Handshake: transfer = valid & ready. ready is combinational from both valids and starve_cnt only; it never depends on ready.
//  - Grant: only one valid -> it wins. Both valid -> LSU wins unless starve_cnt==STARVE_MAX, then ALU wins.
//  - Loser keeps valid/idx/data stable; no internal buffering.
//  - starve_cnt (width clog2(STARVE_MAX+1)):
//      +1 on a cycle where both are valid and LSU is granted;
//      cleared when ALU is granted or alu_wbck_valid=0; never exceeds STARVE_MAX.
//  - Latency: 1 cycle. A transfer in cycle N drives rf_* in cycle N+1. The regfile captures it at the end of N+1.
//  - No transfer: rf_wen=0 next cycle; rf_idx/rf_data hold their previous value.
//  - idx==0: transfer completes, rf_wen=0 (x0 never written).
//  - LSU transfer with lsu_wbck_err=1: rf_wen=0, wbck_lsu_err=1 next cycle, rf_idx=faulting idx.
//  - Full throughput: one write per cycle, no bubbles, no stall input (the regfile always accepts).
// CONFIGURATION
//  CPU5_WBCK_FWD_EN defined adds outputs:
//      fwd_valid  out  1        =rf_wen
//      fwd_idx    out  RFIDX_W  =rf_idx
//      fwd_data   out  XLEN     =rf_data
//    Decode muxes fwd_data for rs1/rs2 when fwd_idx matches, closing the write-then-read window.
//  CPU5_WBCK_FWD_EN undefined: the ports are absent. Decode must interlock one cycle on a matching rf_idx.
// STRUCTURE
//  - defines.v gains `CPU5_WBCK_STARVE_MAX (default 4). It keeps `CPU5_XLEN and `CPU5_RFIDX_WIDTH.
//  - One sub-module, cpu5_wbck_arb: 2-way priority grant plus starve_cnt; outputs alu_grant/lsu_grant.
//  - Top level: grant mux, registered output stage, error pulse.
// TESTING
//  1. ALU only: valid idx=3 data=0x11 in cycle N -> ready=1 in N; rf_wen=1 idx=3 data=0x11 in N+1.
//  2. Collision: both valid for 6 cycles, STARVE_MAX=4, lsu always valid
//     -> grants L,L,L,L,A,L; ALU ready only in cycle 5.
//  3. idx=0: ALU valid idx=0 data=0xFF -> ready=1, rf_wen=0 next cycle.
//  4. LSU err: valid err=1 idx=7 -> ready=1; next cycle rf_wen=0, wbck_lsu_err=1 for exactly 1 cycle.
//  5. Reset mid-stream: rst=0 while a transfer is pending
//     -> next cycle rf_wen=0, wbck_lsu_err=0, starve_cnt=0; after release, LSU wins first collision.
//  6. FWD_EN: ALU write idx=5 data=0xA5 -> fwd_valid=1 fwd_idx=5 fwd_data=0xA5 same cycle as rf_wen;
//     regfile read of x5 returns 0xA5 the following cycle.

Source files
------------

// File: rtl/cpu5_wbck_pkg.sv
// Shared widths and defaults for the cpu5 writeback stage.
// Optional forwarding outputs are enabled in the top by defining CPU5_WBCK_FWD_EN.
package cpu5_wbck_pkg;
  localparam int CPU5_XLEN        = 32;
  localparam int CPU5_RFIDX_WIDTH = 5;
  localparam int CPU5_STARVE_MAX  = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } gnt_e;
endpackage

// File: rtl/cpu5_wbck_arb.sv
// Two-way writeback grant: loads win collisions, but after STARVE_MAX
// consecutive losses the ALU is forced through once.
module cpu5_wbck_arb
  import cpu5_wbck_pkg::*;
#(
  parameter int STARVE_MAX = CPU5_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_grant,
  output logic lsu_grant,
  output gnt_e gnt
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  always_comb begin
    alu_grant = alu_valid & (~lsu_valid | starved);
    lsu_grant = lsu_valid & ~alu_grant;
    gnt       = GNT_NONE;
    if (alu_grant)      gnt = GNT_ALU;
    else if (lsu_grant) gnt = GNT_LSU;
  end

  // Counts only real collisions lost by the ALU; a forced ALU grant clears it,
  // so it can never pass STARVE_MAX.
  always_ff @(posedge clk) begin
    if (!rst)
      starve_cnt <= '0;
    else if (alu_valid & lsu_valid & lsu_grant)
      starve_cnt <= starve_cnt + CW'(1);
    else
      starve_cnt <= '0;
  end
endmodule

// File: rtl/cpu5_wbck.sv
// Writeback stage: arbitrates ALU/LSU results into one registered regfile write.
// Define CPU5_WBCK_FWD_EN to expose fwd_valid/fwd_idx/fwd_data for decode bypass.
module cpu5_wbck
  import cpu5_wbck_pkg::*;
#(
  parameter int XLEN       = CPU5_XLEN,
  parameter int RFIDX_W    = CPU5_RFIDX_WIDTH,
  parameter int STARVE_MAX = CPU5_STARVE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_valid,
  output logic               alu_wbck_ready,
  input  logic [RFIDX_W-1:0] alu_wbck_idx,
  input  logic [XLEN-1:0]    alu_wbck_data,
  input  logic               lsu_wbck_valid,
  output logic               lsu_wbck_ready,
  input  logic [RFIDX_W-1:0] lsu_wbck_idx,
  input  logic [XLEN-1:0]    lsu_wbck_data,
  input  logic               lsu_wbck_err,
  output logic               rf_wen,
  output logic [RFIDX_W-1:0] rf_idx,
  output logic [XLEN-1:0]    rf_data,
  output logic               wbck_lsu_err
`ifdef CPU5_WBCK_FWD_EN
  ,
  output logic               fwd_valid,
  output logic [RFIDX_W-1:0] fwd_idx,
  output logic [XLEN-1:0]    fwd_data
`endif
);
  logic               alu_grant, lsu_grant, xfer, win_err;
  gnt_e               gnt;
  logic [RFIDX_W-1:0] win_idx;
  logic [XLEN-1:0]    win_data;

  cpu5_wbck_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_wbck_valid),
    .lsu_valid (lsu_wbck_valid),
    .alu_grant (alu_grant),
    .lsu_grant (lsu_grant),
    .gnt       (gnt)
  );

  assign alu_wbck_ready = alu_grant;
  assign lsu_wbck_ready = lsu_grant;

  always_comb begin
    xfer     = (gnt != GNT_NONE);
    win_idx  = alu_wbck_idx;
    win_data = alu_wbck_data;
    win_err  = 1'b0;
    if (gnt == GNT_LSU) begin
      win_idx  = lsu_wbck_idx;
      win_data = lsu_wbck_data;
      win_err  = lsu_wbck_err;
    end
  end

  // x0 and faulted loads still retire (idx/data latched) but never write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen       <= 1'b0;
      rf_idx       <= '0;
      rf_data      <= '0;
      wbck_lsu_err <= 1'b0;
    end else begin
      rf_wen       <= xfer & (|win_idx) & ~win_err;
      wbck_lsu_err <= xfer & win_err;
      if (xfer) begin
        rf_idx  <= win_idx;
        rf_data <= win_data;
      end
    end
  end

`ifdef CPU5_WBCK_FWD_EN
  assign fwd_valid = rf_wen;
  assign fwd_idx   = rf_idx;
  assign fwd_data  = rf_data;
`endif
endmodule

// File: tb/tb_cpu5_wbck.sv
// Directed bench for cpu5_wbck: per-cycle expected writes go through a scoreboard queue.
module tb_cpu5_wbck;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wbck_valid, alu_wbck_ready;
  logic [4:0]  alu_wbck_idx;
  logic [31:0] alu_wbck_data;
  logic        lsu_wbck_valid, lsu_wbck_ready;
  logic [4:0]  lsu_wbck_idx;
  logic [31:0] lsu_wbck_data;
  logic        lsu_wbck_err;
  logic        rf_wen;
  logic [4:0]  rf_idx;
  logic [31:0] rf_data;
  logic        wbck_lsu_err;
`ifdef CPU5_WBCK_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;
`endif

  cpu5_wbck dut (
    .clk            (clk),
    .rst            (rst),
    .alu_wbck_valid (alu_wbck_valid),
    .alu_wbck_ready (alu_wbck_ready),
    .alu_wbck_idx   (alu_wbck_idx),
    .alu_wbck_data  (alu_wbck_data),
    .lsu_wbck_valid (lsu_wbck_valid),
    .lsu_wbck_ready (lsu_wbck_ready),
    .lsu_wbck_idx   (lsu_wbck_idx),
    .lsu_wbck_data  (lsu_wbck_data),
    .lsu_wbck_err   (lsu_wbck_err),
    .rf_wen         (rf_wen),
    .rf_idx         (rf_idx),
    .rf_data        (rf_data),
    .wbck_lsu_err   (wbck_lsu_err)
`ifdef CPU5_WBCK_FWD_EN
    ,
    .fwd_valid      (fwd_valid),
    .fwd_idx        (fwd_idx),
    .fwd_data       (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check readies, push expectation, compare after posedge.
  task automatic cyc(input logic r,
                     input logic av, input logic [4:0] ai, input logic [31:0] ad,
                     input logic lv, input logic [4:0] li, input logic [31:0] ld,
                     input logic le,
                     input logic chk_rdy, input logic exp_ar, input logic exp_lr);
    exp_t e, got;
    @(negedge clk);
    rst = r;
    alu_wbck_valid = av; alu_wbck_idx = ai; alu_wbck_data = ad;
    lsu_wbck_valid = lv; lsu_wbck_idx = li; lsu_wbck_data = ld; lsu_wbck_err = le;
    #1;
    if (chk_rdy) begin
      chk("alu_ready", 32'(alu_wbck_ready), 32'(exp_ar));
      chk("lsu_ready", 32'(lsu_wbck_ready), 32'(exp_lr));
    end
    if (!r) begin
      m_idx = '0; m_data = '0;
      e = '{wen: 1'b0, idx: 5'd0, data: 32'd0, err: 1'b0};
    end else if (exp_ar) begin
      m_idx = ai; m_data = ad;
      e = '{wen: (ai != 0), idx: ai, data: ad, err: 1'b0};
    end else if (exp_lr) begin
      m_idx = li; m_data = ld;
      e = '{wen: (li != 0) && !le, idx: li, data: ld, err: le};
    end else begin
      e = '{wen: 1'b0, idx: m_idx, data: m_data, err: 1'b0};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      got = sb.pop_front();
      chk("rf_wen",       32'(rf_wen),       32'(got.wen));
      chk("rf_idx",       32'(rf_idx),       32'(got.idx));
      chk("rf_data",      rf_data,           got.data);
      chk("wbck_lsu_err", 32'(wbck_lsu_err), 32'(got.err));
`ifdef CPU5_WBCK_FWD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(got.wen));
      chk("fwd_idx",   32'(fwd_idx),   32'(got.idx));
      chk("fwd_data",  fwd_data,       got.data);
`endif
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    alu_wbck_valid = 1'b0; alu_wbck_idx = '0; alu_wbck_data = '0;
    lsu_wbck_valid = 1'b0; lsu_wbck_idx = '0; lsu_wbck_data = '0; lsu_wbck_err = 1'b0;
    m_idx = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_wen",  32'(rf_wen),       32'd0);
    chk("reset_rf_idx",  32'(rf_idx),       32'd0);
    chk("reset_rf_data", rf_data,           32'd0);
    chk("reset_err",     32'(wbck_lsu_err), 32'd0);

    // ALU-only write, then an idle cycle that must hold idx/data.
    cyc(1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();

    // Sustained collision: L,L,L,L,A,L.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 5'd9, 32'hA1, 1'b1, 5'd10, 32'h100 + 32'(i), 1'b0,
          1'b1, (i == 4), (i != 4));
    idle();

    // Write to x0 retires without a write.
    cyc(1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Faulting load: error pulse for exactly one cycle, no write.
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h55, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-collision must clear the starvation count.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 5'd4, 32'hC4, 1'b1, 5'd6, 32'h200 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 5'd4, 32'hC4, 1'b1, 5'd6, 32'h2FF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 5'd4, 32'hC4, 1'b1, 5'd6, 32'h300 + 32'(i), 1'b0,
          1'b1, (i == 4), (i != 4));

    // Back-to-back writes from alternating producers, no bubbles.
    cyc(1'b1, 1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
